// File: rtl/my_fsm_pkg.sv
// rtl/my_fsm_pkg.sv - state encoding and output mask for the serial pattern FSM
//
// Purpose : shared state type and decode constants for my_fsm_seq.
// Contents: state_t      - 3-bit binary state encoding, IDLE = 0
//           OUT_HIGH     - one bit per state code, set where the Moore output is 1
//           out_of_state - decode helper built on OUT_HIGH
package my_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT1   = 3'd1,
    GOT10  = 3'd2,
    GOT100 = 3'd3,
    ARMED  = 3'd4,
    DROP   = 3'd5,
    HOLD   = 3'd6,
    WAIT   = 3'd7
  } state_t;

  // Bit n set means state code n drives out=1 (ARMED=4, HOLD=6).
  localparam logic [7:0] OUT_HIGH = 8'b0101_0000;

  function automatic logic out_of_state(input state_t s);
    return OUT_HIGH[s];
  endfunction

endpackage

// File: rtl/my_fsm_seq.sv
// rtl/my_fsm_seq.sv - Moore FSM detecting the serial pattern 1,0,0,0 and its follow-on arcs
//
// Purpose: watches a 1-bit stream sampled each rising clock edge and drives a
//          level flag that is high only in the ARMED and HOLD states.
// Ports  : clock - single clock, all state changes on the rising edge
//          reset - synchronous, active-low reset (low at an edge -> IDLE, out=0)
//          in    - serial data bit, sampled on each rising edge
//          out   - registered Moore output
module my_fsm_seq
  import my_fsm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_t r_state;
  state_t w_next;
  logic   r_out;

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = in ? GOT1  : IDLE;
      GOT1:    w_next = in ? GOT1  : GOT10;
      GOT10:   w_next = in ? GOT1  : GOT100;
      GOT100:  w_next = in ? GOT1  : ARMED;
      ARMED:   w_next = in ? DROP  : ARMED;
      DROP:    w_next = in ? WAIT  : HOLD;
      HOLD:    w_next = ARMED;
      WAIT:    w_next = in ? HOLD  : IDLE;
      // A corrupt state register recovers to IDLE on the next edge.
      default: w_next = IDLE;
    endcase
  end

  // The output is registered from the next-state decode so that it changes
  // in step with the state register and cannot glitch between edges.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= out_of_state(w_next);
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_my_fsm_seq.sv
// tb/tb_my_fsm_seq.sv - directed self-checking bench for my_fsm_seq
module tb_my_fsm_seq;
  import my_fsm_pkg::*;

  logic clock;
  logic reset;
  logic in;
  logic out;

  int n_cmp;
  int n_bad;

  my_fsm_seq dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-written transition table: exp_next[state][in].
  function automatic logic [2:0] exp_next(input logic [2:0] s, input logic b);
    logic [2:0] t0 [8];
    logic [2:0] t1 [8];
    t0 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd4, 3'd0};
    t1 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd5, 3'd7, 3'd4, 3'd6};
    return b ? t1[s] : t0[s];
  endfunction

  // Drive one bit at the falling edge, then sample just after the rising edge.
  task automatic step(input logic b);
    @(negedge clock);
    in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    in    = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_seq(input string name, input logic [15:0] bits,
                         input logic [15:0] exp, input int len);
    for (int i = 0; i < len; i++) begin
      step(bits[len-1-i]);
      n_cmp++;
      if (out !== exp[len-1-i]) begin
        n_bad++;
        $display("FAIL %s step %0d: out=%b expected %b", name, i, out, exp[len-1-i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    in    = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    in = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: out=%b expected 0", out);
    end
    n_cmp++;
    if (dut.r_state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d expected 0", dut.r_state);
    end
    @(negedge clock);
    reset = 1'b1;
    in    = 1'b0;
    run_seq("reset_release", 16'b000, 16'b000, 3);
  endtask

  task automatic test_trigger();
    do_reset();
    run_seq("trigger", 16'b100000, 16'b000111, 6);
  endtask

  task automatic test_full_stream();
    do_reset();
    run_seq("full_stream", 16'b100_0101_0111, 16'b000_1011_1001, 11);
  endtask

  task automatic test_near_miss();
    do_reset();
    run_seq("near_miss", 16'b100_1000, 16'b000_0001, 7);
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_seq("mid_reset_arm", 16'b1000, 16'b0001, 4);
    @(negedge clock);
    reset = 1'b0;
    in    = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (out !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_out: out=%b expected 0", out);
    end
    n_cmp++;
    if (dut.r_state !== IDLE) begin
      n_bad++;
      $display("FAIL mid_reset_state: state=%0d expected 0", dut.r_state);
    end
    @(negedge clock);
    reset = 1'b1;
    run_seq("mid_reset_release", 16'b0, 16'b0, 1);
  endtask

  // Every arc: reset, walk a known path into state s, apply bit b, check
  // both the landing state and the Moore output of that state.
  task automatic test_all_arcs();
    logic [7:0] path [8];
    int         plen [8];
    logic [2:0] want;
    logic       want_out;
    path = '{8'b0, 8'b1, 8'b10, 8'b100, 8'b1000, 8'b10001, 8'b100010, 8'b100011};
    plen = '{0, 1, 2, 3, 4, 5, 6, 7};
    for (int s = 0; s < 8; s++) begin
      for (int b = 0; b < 2; b++) begin
        do_reset();
        for (int i = 0; i < plen[s]; i++) step(path[s][plen[s]-1-i]);
        n_cmp++;
        if (dut.r_state !== 3'(s)) begin
          n_bad++;
          $display("FAIL arc_reach s%0d: state=%0d expected %0d", s, dut.r_state, s);
        end
        step(b[0]);
        want     = exp_next(3'(s), b[0]);
        want_out = (want == 3'd4) || (want == 3'd6);
        n_cmp++;
        if (dut.r_state !== want) begin
          n_bad++;
          $display("FAIL arc s%0d in%0d: state=%0d expected %0d", s, b, dut.r_state, want);
        end
        n_cmp++;
        if (out !== want_out) begin
          n_bad++;
          $display("FAIL arc_out s%0d in%0d: out=%b expected %b", s, b, out, want_out);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    in    = 1'b0;
    test_reset();
    test_trigger();
    test_full_stream();
    test_near_miss();
    test_mid_reset();
    test_all_arcs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
